// File: rtl/memory_bus_arbiter_pkg.sv
// arbiter_pkg: shared state/requester types and wait-counter width for memory_bus_arbiter.
package arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} arb_state_t;
  typedef enum logic {REQ_FETCH = 1'b0, REQ_DATA = 1'b1} req_id_t;
  localparam int WAIT_CNT_WIDTH = 4;
endpackage

// File: rtl/memory_bus_arbiter_if.sv
// memory_bus_arbiter_if: requester handshakes and RAM port; slave = arbiter side, master = core/RAM side.
interface memory_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  halt;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_grant;
  logic                  fetch_ready;
  logic [DATA_WIDTH-1:0] fetch_rdata;
  logic                  data_req;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic                  data_we;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic                  data_grant;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read_enable;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport slave (
    input  halt, fetch_req, fetch_addr, data_req, data_addr, data_we, data_wdata, mem_rdata,
    output fetch_grant, fetch_ready, fetch_rdata, data_grant, data_ready, data_rdata,
           mem_addr, mem_read_enable, mem_write_enable, mem_wdata
  );
  modport master (
    output halt, fetch_req, fetch_addr, data_req, data_addr, data_we, data_wdata, mem_rdata,
    input  fetch_grant, fetch_ready, fetch_rdata, data_grant, data_ready, data_rdata,
           mem_addr, mem_read_enable, mem_write_enable, mem_wdata
  );
endinterface

// File: rtl/memory_bus_arbiter_wait_state_counter.sv
// wait_state_counter: loadable down-counter that stops at zero and flags it.
module wait_state_counter
  import arbiter_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic                      dec,
  input  logic [WAIT_CNT_WIDTH-1:0] load_val,
  output logic                      zero
);
  logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin fetch/data arbiter for a single-port RAM with fixed wait states.
// Define ARB_PERF_COUNTERS_EN to add saturating per-requester grant counters.
module memory_bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic clock,
  input  logic reset_n,
  memory_bus_arbiter_if.slave bus
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [15:0] fetch_grant_count,
  output logic [15:0] data_grant_count
`endif
);
  arb_state_t            state_q, state_d;
  req_id_t               owner_q, owner_d, last_owner_q, last_owner_d, pick;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] fetch_rdata_q, fetch_rdata_d, data_rdata_q, data_rdata_d;
  logic                  start, done, zero, in_access, is_data;
  always_comb begin
    start         = (state_q == IDLE) && !bus.halt && (bus.fetch_req || bus.data_req);
    done          = (state_q == ACCESS) && zero;
    // On a tie the requester that did not own the last access wins.
    pick          = (bus.fetch_req && bus.data_req) ? ((last_owner_q == REQ_FETCH) ? REQ_DATA : REQ_FETCH)
                  : (bus.data_req ? REQ_DATA : REQ_FETCH);
    state_d       = start ? ACCESS : done ? RESPOND : (state_q == RESPOND) ? IDLE : state_q;
    owner_d       = start ? pick : owner_q;
    last_owner_d  = (state_q == RESPOND) ? owner_q : last_owner_q;
    addr_d        = start ? ((pick == REQ_DATA) ? bus.data_addr : bus.fetch_addr) : addr_q;
    we_d          = start ? ((pick == REQ_DATA) && bus.data_we) : we_q;
    wdata_d       = start ? bus.data_wdata : wdata_q;
    fetch_rdata_d = (done && owner_q == REQ_FETCH) ? bus.mem_rdata : fetch_rdata_q;
    data_rdata_d  = (done && owner_q == REQ_DATA && !we_q) ? bus.mem_rdata : data_rdata_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      owner_q       <= REQ_FETCH;
      last_owner_q  <= REQ_DATA;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end
  wait_state_counter u_wait (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (start),
    .dec      (state_q == ACCESS),
    .load_val (WAIT_CNT_WIDTH'(WAIT_STATES)),
    .zero     (zero)
  );
  // Outputs decode straight from state so reset clears them without a clock edge.
  assign in_access            = (state_q == ACCESS);
  assign is_data              = (owner_q == REQ_DATA);
  assign bus.fetch_grant      = in_access && !is_data;
  assign bus.data_grant       = in_access && is_data;
  assign bus.fetch_ready      = (state_q == RESPOND) && !is_data;
  assign bus.data_ready       = (state_q == RESPOND) && is_data;
  assign bus.fetch_rdata      = fetch_rdata_q;
  assign bus.data_rdata       = data_rdata_q;
  assign bus.mem_addr         = in_access ? addr_q : '0;
  assign bus.mem_read_enable  = in_access && !(is_data && we_q);
  assign bus.mem_write_enable = in_access && is_data && we_q;
  assign bus.mem_wdata        = (in_access && is_data && we_q) ? wdata_q : '0;
`ifdef ARB_PERF_COUNTERS_EN
  logic [15:0] fcnt_q, fcnt_d, dcnt_q, dcnt_d;
  always_comb begin
    fcnt_d = (start && pick == REQ_FETCH && fcnt_q != 16'hFFFF) ? fcnt_q + 16'd1 : fcnt_q;
    dcnt_d = (start && pick == REQ_DATA && dcnt_q != 16'hFFFF) ? dcnt_q + 16'd1 : dcnt_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      dcnt_q <= dcnt_d;
    end
  end
  assign fetch_grant_count = fcnt_q;
  assign data_grant_count  = dcnt_q;
`endif
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed checks of memory_bus_arbiter (WAIT_STATES=1 and WAIT_STATES=0 instances).
module tb_memory_bus_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   wr_cnt = 0;
  logic [7:0] last_wa = '0, last_wd = '0;
  memory_bus_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) ifc ();
  memory_bus_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) ifc0 ();
`ifdef ARB_PERF_COUNTERS_EN
  logic [15:0] fgc, dgc, fgc0, dgc0;
`endif
  memory_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(1)) dut (
    .clock (clock), .reset_n (reset_n), .bus (ifc)
`ifdef ARB_PERF_COUNTERS_EN
    , .fetch_grant_count (fgc), .data_grant_count (dgc)
`endif
  );
  memory_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clock (clock), .reset_n (reset_n), .bus (ifc0)
`ifdef ARB_PERF_COUNTERS_EN
    , .fetch_grant_count (fgc0), .data_grant_count (dgc0)
`endif
  );
  always #5 clock = ~clock;
  function automatic logic [7:0] rom(logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction
  assign ifc.mem_rdata  = rom(ifc.mem_addr);
  assign ifc0.mem_rdata = rom(ifc0.mem_addr);
  always @(posedge clock) begin
    if (ifc.mem_write_enable) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= ifc.mem_addr;
      last_wd <= ifc.mem_wdata;
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] outs();
    return {ifc.fetch_grant, ifc.fetch_ready, ifc.data_grant, ifc.data_ready,
            ifc.mem_read_enable, ifc.mem_write_enable, |ifc.mem_addr, |ifc.mem_wdata};
  endfunction
  initial begin
    logic fg, dg, pf, pd;
    int   n_f, n_d;
    logic [1:0] order[$];
    {ifc.halt, ifc.fetch_req, ifc.data_req, ifc.data_we} = '0;
    {ifc.fetch_addr, ifc.data_addr, ifc.data_wdata} = '0;
    {ifc0.halt, ifc0.fetch_req, ifc0.data_req, ifc0.data_we} = '0;
    ifc0.fetch_addr = 8'h10; ifc0.data_addr = 8'h30; ifc0.data_wdata = '0;
    #1;
    chk("reset_outs", outs(), 8'h00);
    chk("reset_rdata", {ifc.fetch_rdata, ifc.data_rdata}, 16'h0000);
    step(); step();
    reset_n = 1'b1;
    step();
    // Single fetch read.
    ifc.fetch_req = 1'b1; ifc.fetch_addr = 8'h10;
    step();
    chk("f1_grant", {ifc.fetch_grant, ifc.data_grant, ifc.mem_read_enable, ifc.mem_write_enable}, 4'b1010);
    chk("f1_addr", ifc.mem_addr, 8'h10);
    step();
    chk("f1_grant2", {ifc.fetch_grant, ifc.fetch_ready, ifc.mem_read_enable}, 3'b101);
    step();
    chk("f1_ready", {ifc.fetch_grant, ifc.fetch_ready, ifc.mem_read_enable}, 3'b010);
    chk("f1_rdata", ifc.fetch_rdata, 8'hA5);
    ifc.fetch_req = 1'b0;
    step();
    chk("f1_pulse", ifc.fetch_ready, 1'b0);
    // Data write; wdata changed after grant must not leak into the access.
    ifc.data_req = 1'b1; ifc.data_we = 1'b1; ifc.data_addr = 8'h20; ifc.data_wdata = 8'h3C;
    step();
    chk("w_strobes", {ifc.data_grant, ifc.fetch_grant, ifc.mem_write_enable, ifc.mem_read_enable}, 4'b1010);
    chk("w_addr", {ifc.mem_addr, ifc.mem_wdata}, 16'h203C);
    ifc.data_wdata = 8'hFF; ifc.data_addr = 8'h99;
    step();
    chk("w_hold", {ifc.mem_write_enable, ifc.mem_read_enable, ifc.mem_addr, ifc.mem_wdata}, {2'b10, 16'h203C});
    step();
    chk("w_ready", {ifc.data_ready, ifc.data_grant, ifc.mem_write_enable}, 3'b100);
    chk("w_rdata", ifc.data_rdata, 8'h00);
    ifc.data_req = 1'b0;
    step();
    chk("w_ram", {wr_cnt[7:0], last_wa, last_wd}, {8'd2, 8'h20, 8'h3C});
    // Another fetch so the last owner becomes FETCH before the mid-access reset.
    ifc.fetch_req = 1'b1; ifc.fetch_addr = 8'h11;
    step(); step(); step();
    chk("f2_rdata", {ifc.fetch_ready, ifc.fetch_rdata}, {1'b1, 8'h4B});
    ifc.fetch_req = 1'b0;
    step();
    // Reset in the middle of a write access.
    ifc.data_req = 1'b1; ifc.data_we = 1'b1; ifc.data_addr = 8'h40; ifc.data_wdata = 8'h77;
    step();
    chk("rst_pre", ifc.mem_write_enable, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async", outs(), 8'h00);
    chk("rst_rdata", {ifc.fetch_rdata, ifc.data_rdata}, 16'h0000);
    // Contention from reset release: FETCH, DATA, FETCH, DATA.
    ifc.data_we = 1'b0; ifc.data_addr = 8'h30; ifc.fetch_addr = 8'h10;
    ifc.fetch_req = 1'b1; ifc.data_req = 1'b1;
    step();
    reset_n = 1'b1;
    pf = 1'b0; pd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      fg = ifc.fetch_grant; dg = ifc.data_grant;
      chk("c_onehot", {fg, dg} == 2'b11, 1'b0);
      chk("c_rw_excl", ifc.mem_read_enable && ifc.mem_write_enable, 1'b0);
      if (fg && !pf) order.push_back(2'd1);
      if (dg && !pd) order.push_back(2'd2);
      pf = fg; pd = dg;
    end
    ifc.fetch_req = 1'b0; ifc.data_req = 1'b0;
    chk("c_count", order.size(), 4);
    while (order.size() < 4) order.push_back(2'd0);
    chk("c_order", {order[0], order[1], order[2], order[3]}, 8'b01_10_01_10);
    chk("c_rdata", {ifc.fetch_rdata, ifc.data_rdata}, 16'hA56A);
    // Halt raised during a data read, with a fetch pending.
    ifc.data_req = 1'b1; ifc.data_addr = 8'h31;
    step();
    chk("h_grant", ifc.data_grant, 1'b1);
    ifc.halt = 1'b1; ifc.fetch_req = 1'b1; ifc.fetch_addr = 8'h12;
    step();
    chk("h_access", ifc.data_grant, 1'b1);
    step();
    chk("h_ready", {ifc.data_ready, ifc.data_rdata}, {1'b1, 8'h6B});
    ifc.data_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("h_blocked", {ifc.fetch_grant, ifc.data_grant}, 2'b00);
    end
    ifc.halt = 1'b0;
    step();
    chk("h_resume", ifc.fetch_grant, 1'b1);
    step(); step();
    chk("h_fetch", {ifc.fetch_ready, ifc.fetch_rdata}, {1'b1, 8'h48});
    ifc.fetch_req = 1'b0;
    step();
`ifdef ARB_PERF_COUNTERS_EN
    chk("perf_main", {fgc, dgc}, {16'd3, 16'd3});
`endif
    // WAIT_STATES=0 instance: five contended reads, each access one cycle.
    ifc0.fetch_req = 1'b1; ifc0.data_req = 1'b1;
    n_f = 0; n_d = 0; pf = 1'b0; pd = 1'b0;
    for (int i = 0; i < 20 && (n_f + n_d) < 5; i++) begin
      step();
      fg = ifc0.fetch_grant; dg = ifc0.data_grant;
      chk("z_one_cycle", {fg && pf, dg && pd, fg && dg}, 3'b000);
      if (fg && !pf) n_f++;
      if (dg && !pd) n_d++;
      pf = fg; pd = dg;
    end
    ifc0.fetch_req = 1'b0; ifc0.data_req = 1'b0;
    chk("z_counts", {n_f[7:0], n_d[7:0]}, {8'd3, 8'd2});
    step();
    chk("z_end", {ifc0.fetch_grant, ifc0.data_grant, ifc0.fetch_ready}, 3'b001);
    step();
    chk("z_rdata", {ifc0.fetch_rdata, ifc0.data_rdata}, 16'hA56A);
`ifdef ARB_PERF_COUNTERS_EN
    chk("perf_ws0", {fgc0, dgc0}, {16'd3, 16'd2});
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters: instruction fetch (program counter side) and data access (microcode load/store side).
- Uses a request/grant/ready handshake with round-robin arbitration and a fixed wait-state count per access.
- Sits between the execution core and the RAM. A halt input blocks new grants so the core can stop cleanly.

Parameters:
- ADDR_WIDTH, 8, width of all address buses.
- DATA_WIDTH, 8, width of all data buses.
- WAIT_STATES, 1, extra cycles the RAM port is held per access (0..15).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- halt  in  1  level; while high, no new grant is issued.
- fetch_req  in  1  fetch requester wants an access; held until fetch_ready.
- fetch_addr  in  ADDR_WIDTH  fetch address (read only).
- fetch_grant  out  1  high while the fetch access owns the RAM port.
- fetch_ready  out  1  one-cycle pulse; fetch_rdata valid.
- fetch_rdata  out  DATA_WIDTH  captured read data.
- data_req  in  1  data requester wants an access; held until data_ready.
- data_addr  in  ADDR_WIDTH  data address.
- data_we  in  1  1 = write, 0 = read; sampled at grant.
- data_wdata  in  DATA_WIDTH  write data; sampled at grant.
- data_grant  out  1  high while the data access owns the RAM port.
- data_ready  out  1  one-cycle pulse; write done, or data_rdata valid.
- data_rdata  out  DATA_WIDTH  captured read data.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_read_enable  out  1  RAM read strobe.
- mem_write_enable  out  1  RAM write strobe.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - all grant, ready and mem_* outputs = 0;
  - fetch_rdata and data_rdata = 0;
  - state = IDLE;
  - last_owner = DATA, so fetch wins the first tie.
- IDLE:
  - if halt = 1, or neither request is high: stay in IDLE.
  - else pick the owner: a single requester wins outright; if both are high, the requester that is not last_owner wins.
  - latch addr/we/wdata of the winner into the access registers; load wait counter = WAIT_STATES; go to ACCESS.
- ACCESS:
  - the winner's grant = 1; mem_addr is driven from the latched address.
  - fetch access: mem_read_enable = 1.
  - data access: mem_read_enable = !we and mem_write_enable = we, for every ACCESS cycle.
  - duration is WAIT_STATES+1 cycles; the counter decrements each cycle.
  - on the cycle the counter = 0: capture mem_rdata (reads only) into the owner's rdata register; go to RESPOND.
- RESPOND:
  - all mem_* = 0 and grants = 0; the owner's ready = 1 for exactly one cycle.
  - last_owner = owner; go to IDLE.
- Latency: request seen in IDLE at edge N:
  - grant from N+1;
  - ready at N+WAIT_STATES+2;
  - next grant no earlier than N+WAIT_STATES+4.
- rdata registers hold their value until the next read by the same requester. Write accesses do not change data_rdata.
- Request dropped during ACCESS: the access still completes, and ready still pulses (ignored by the requester).
- halt rising during ACCESS: the current access completes normally; the block then parks in IDLE.
- Address, we and wdata changes after grant have no effect on the access in flight.
- Never more than one grant is high at a time. mem_read_enable and mem_write_enable are never both high.
- WAIT_STATES = 0: ACCESS lasts exactly 1 cycle.

Optional Feature:
- Macro ARB_PERF_COUNTERS_EN.
- Defined:
  - adds outputs fetch_grant_count [15:0] and data_grant_count [15:0];
  - each increments on entry to ACCESS for its requester, saturating at 16'hFFFF;
  - both cleared by reset_n.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package arbiter_pkg:
  - state enum arb_state_t {IDLE, ACCESS, RESPOND};
  - requester enum req_id_t {REQ_FETCH = 0, REQ_DATA = 1};
  - constant WAIT_CNT_WIDTH = 4.
- Sub-module wait_state_counter: load, decrement, zero flag; width WAIT_CNT_WIDTH. Instantiated once.

Test Plan:
- Single fetch read:
  - stimulus: WAIT_STATES=1, mem returns 8'hA5 at fetch_addr 8'h10; fetch_req at edge 0.
  - response: fetch_grant edges 1-2, mem_read_enable=1 and mem_addr=8'h10 during those cycles, fetch_ready pulse at edge 3 with fetch_rdata=8'hA5.
- Data write:
  - stimulus: data_we=1, data_addr=8'h20, data_wdata=8'h3C.
  - response: mem_write_enable=1 for 2 cycles with mem_wdata=8'h3C, mem_read_enable=0, data_ready one pulse, data_rdata unchanged.
- Contention:
  - stimulus: both requests held high from reset release.
  - response: grant order FETCH, DATA, FETCH, DATA; never two grants high at once.
- Halt:
  - stimulus: assert halt mid-ACCESS of a data read.
  - response: the access completes with data_ready; no further grant while halt=1; the pending fetch is granted 1 cycle after halt falls.
- Reset mid-access:
  - stimulus: reset_n low during a write ACCESS.
  - response: mem_write_enable drops without waiting for a clock edge; all outputs = 0; after release, fetch wins the first tie.
- WAIT_STATES=0 with ARB_PERF_COUNTERS_EN defined:
  - stimulus: 3 fetch reads and 2 data reads.
  - response: every ACCESS lasts 1 cycle; fetch_grant_count=3, data_grant_count=2.
